// File: rtl/fetch_stage.sv
// RV32i instruction fetch stage: PC register, next-PC selection and decode-side PC/prediction registers.
// Optional direct-mapped branch target buffer enabled by defining FETCH_BTB_EN.
module fetch_stage #(
  parameter logic [11:0] RESET_PC    = 12'h000,
  parameter int unsigned BTB_ENTRIES = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        Stall_En,
  input  logic        Redirect_En_E,
  input  logic [11:0] Redirect_Target_E,
  input  logic        Update_En_E,
  input  logic [11:0] Update_PC_E,
  input  logic        Update_Taken_E,
  input  logic [11:0] Update_Target_E,
  output logic [11:0] PC_F,
  output logic [11:0] PC_D,
  output logic        Pred_Taken_D,
  output logic [11:0] Pred_Target_D
);

  localparam int unsigned PCW = 12;

  logic [PCW-1:0] pc_f_q, pc_f_d;
  logic [PCW-1:0] pc_d_q;
  logic           pred_taken_c;
  logic [PCW-1:0] pred_target_c;

`ifdef FETCH_BTB_EN
  localparam int unsigned IDXW = $clog2(BTB_ENTRIES);
  localparam int unsigned TAGW = PCW - 2 - IDXW;

  logic [BTB_ENTRIES-1:0] valid_q;
  logic [TAGW-1:0]        tag_q [BTB_ENTRIES];
  logic [PCW-1:0]         tgt_q [BTB_ENTRIES];
  logic [1:0]             ctr_q [BTB_ENTRIES];

  logic [IDXW-1:0] lk_idx_c, up_idx_c;
  logic [TAGW-1:0] lk_tag_c, up_tag_c;
  logic            lk_hit_c, up_hit_c;
  logic            pred_taken_q;
  logic [PCW-1:0]  pred_target_q;
  logic            unused_c;

  assign unused_c = ^{Redirect_Target_E[1:0], Update_PC_E[1:0], Update_Target_E[1:0]};

  // Lookup reads pre-update contents; writes land at the edge.
  assign lk_idx_c      = pc_f_q[IDXW+1:2];
  assign lk_tag_c      = pc_f_q[PCW-1:IDXW+2];
  assign lk_hit_c      = valid_q[lk_idx_c] && (tag_q[lk_idx_c] == lk_tag_c);
  assign pred_taken_c  = lk_hit_c && (ctr_q[lk_idx_c] >= 2'd2);
  assign pred_target_c = pred_taken_c ? tgt_q[lk_idx_c] : '0;

  assign up_idx_c = Update_PC_E[IDXW+1:2];
  assign up_tag_c = Update_PC_E[PCW-1:IDXW+2];
  assign up_hit_c = valid_q[up_idx_c] && (tag_q[up_idx_c] == up_tag_c);

  // BTB update: saturating counter on hit, allocate on taken miss.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      valid_q <= '0;
    end else if (Update_En_E) begin
      if (up_hit_c) begin
        if (Update_Taken_E) begin
          ctr_q[up_idx_c] <= (ctr_q[up_idx_c] == 2'd3) ? 2'd3 : 2'(ctr_q[up_idx_c] + 2'd1);
          tgt_q[up_idx_c] <= {Update_Target_E[PCW-1:2], 2'b00};
        end else begin
          ctr_q[up_idx_c] <= (ctr_q[up_idx_c] == 2'd0) ? 2'd0 : 2'(ctr_q[up_idx_c] - 2'd1);
        end
      end else if (Update_Taken_E) begin
        valid_q[up_idx_c] <= 1'b1;
        tag_q[up_idx_c]   <= up_tag_c;
        tgt_q[up_idx_c]   <= {Update_Target_E[PCW-1:2], 2'b00};
        ctr_q[up_idx_c]   <= 2'd2;
      end
    end
  end

  // Prediction travels with the instruction; a redirect always kills it.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
    end else begin
      if (!Stall_En) begin
        pred_taken_q  <= pred_taken_c;
        pred_target_q <= pred_target_c;
      end
      if (Redirect_En_E) begin
        pred_taken_q <= 1'b0;
      end
    end
  end

  assign Pred_Taken_D  = pred_taken_q;
  assign Pred_Target_D = pred_target_q;
`else
  logic unused_c;

  assign unused_c = ^{Redirect_Target_E[1:0], Update_En_E, Update_PC_E,
                      Update_Taken_E, Update_Target_E};

  assign pred_taken_c  = 1'b0;
  assign pred_target_c = '0;
  assign Pred_Taken_D  = 1'b0;
  assign Pred_Target_D = '0;
`endif

  // Next-PC priority: redirect, stall, prediction, sequential.
  always_comb begin
    pc_f_d = PCW'(pc_f_q + PCW'(4));
    if (Redirect_En_E) begin
      pc_f_d = {Redirect_Target_E[PCW-1:2], 2'b00};
    end else if (Stall_En) begin
      pc_f_d = pc_f_q;
    end else if (pred_taken_c) begin
      pc_f_d = pred_target_c;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pc_f_q <= RESET_PC;
      pc_d_q <= '0;
    end else begin
      pc_f_q <= pc_f_d;
      if (!Stall_En) begin
        pc_d_q <= pc_f_q;
      end
    end
  end

  assign PC_F = pc_f_q;
  assign PC_D = pc_d_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_fetch_stage;

  localparam int NENT    = 16;
  localparam int RST_VAL = 0;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        Stall_En = 1'b0;
  logic        Redirect_En_E = 1'b0;
  logic [11:0] Redirect_Target_E = '0;
  logic        Update_En_E = 1'b0;
  logic [11:0] Update_PC_E = '0;
  logic        Update_Taken_E = 1'b0;
  logic [11:0] Update_Target_E = '0;
  logic [11:0] PC_F, PC_D, Pred_Target_D;
  logic        Pred_Taken_D;

  int n_checks = 0;
  int n_errors = 0;

  fetch_stage #(.RESET_PC(12'h000), .BTB_ENTRIES(NENT)) dut (
    .CLK(CLK), .RST_N(RST_N), .Stall_En(Stall_En),
    .Redirect_En_E(Redirect_En_E), .Redirect_Target_E(Redirect_Target_E),
    .Update_En_E(Update_En_E), .Update_PC_E(Update_PC_E),
    .Update_Taken_E(Update_Taken_E), .Update_Target_E(Update_Target_E),
    .PC_F(PC_F), .PC_D(PC_D), .Pred_Taken_D(Pred_Taken_D), .Pred_Target_D(Pred_Target_D)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %03h expected %03h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: PC arithmetic mod 4096, BTB as plain integer arrays.
  int m_pc, m_pcd, m_pt, m_ptg;
  bit m_started = 0;
  bit m_v [NENT];
  int m_tag [NENT];
  int m_tgt [NENT];
  int m_ctr [NENT];

  always @(posedge CLK) begin
    int pt, ptg, nxt;
    pt = 0;
    ptg = 0;
`ifdef FETCH_BTB_EN
    begin
      int li;
      li = (m_pc / 4) % NENT;
      if (m_v[li] && m_tag[li] == m_pc / (4 * NENT) && m_ctr[li] >= 2) begin
        pt = 1;
        ptg = m_tgt[li];
      end
    end
`endif
    if (!RST_N) begin
      m_pc = RST_VAL; m_pcd = 0; m_pt = 0; m_ptg = 0;
      for (int i = 0; i < NENT; i++) m_v[i] = 0;
    end else begin
      if (Redirect_En_E) nxt = int'(Redirect_Target_E) / 4 * 4;
      else if (Stall_En) nxt = m_pc;
      else if (pt != 0) nxt = ptg;
      else nxt = (m_pc + 4) % 4096;
      if (!Stall_En) begin
        m_pcd = m_pc; m_pt = pt; m_ptg = ptg;
      end
      if (Redirect_En_E) m_pt = 0;
`ifdef FETCH_BTB_EN
      if (Update_En_E) begin
        int ui, ut;
        ui = (int'(Update_PC_E) / 4) % NENT;
        ut = int'(Update_PC_E) / (4 * NENT);
        if (m_v[ui] && m_tag[ui] == ut) begin
          if (Update_Taken_E) begin
            m_ctr[ui] = (m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3;
            m_tgt[ui] = int'(Update_Target_E) / 4 * 4;
          end else begin
            m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
          end
        end else if (Update_Taken_E) begin
          m_v[ui] = 1; m_tag[ui] = ut;
          m_tgt[ui] = int'(Update_Target_E) / 4 * 4;
          m_ctr[ui] = 2;
        end
      end
`endif
      m_pc = nxt;
    end
    m_started = 1;
  end

  // Every-cycle comparison against the model.
  always @(negedge CLK) begin
    if (m_started) begin
      chk("model_pc_f", int'(PC_F), m_pc);
      chk("model_pc_d", int'(PC_D), m_pcd);
      chk("model_pred_taken", int'(Pred_Taken_D), m_pt);
      chk("model_pred_target", int'(Pred_Target_D), m_ptg);
    end
  end

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic redirect_to(input logic [11:0] t);
    Redirect_En_E = 1'b1;
    Redirect_Target_E = t;
    tick();
    Redirect_En_E = 1'b0;
  endtask

  task automatic btb_update(input logic [11:0] pc, input logic tk, input logic [11:0] tg);
    Update_En_E = 1'b1;
    Update_PC_E = pc;
    Update_Taken_E = tk;
    Update_Target_E = tg;
    tick();
    Update_En_E = 1'b0;
  endtask

  initial begin
    @(negedge CLK);
    tick(); tick(); tick();
    chk("rst_pc_f", int'(PC_F), 'h000);
    chk("rst_pc_d", int'(PC_D), 'h000);
    chk("rst_pred", int'(Pred_Taken_D), 0);
    RST_N = 1'b1;
    chk("seq0_pc_f", int'(PC_F), 'h000);
    tick();
    chk("seq1_pc_f", int'(PC_F), 'h004);
    chk("seq1_pc_d", int'(PC_D), 'h000);
    tick();
    chk("seq2_pc_f", int'(PC_F), 'h008);
    tick();
    chk("seq3_pc_f", int'(PC_F), 'h00C);
    chk("seq3_pc_d", int'(PC_D), 'h008);

    redirect_to(12'hFF4);
    chk("redir_pc_f", int'(PC_F), 'hFF4);
    tick(); tick();
    chk("pre_wrap_pc_f", int'(PC_F), 'hFFC);
    Stall_En = 1'b1;
    tick();
    chk("stall1_pc_f", int'(PC_F), 'hFFC);
    chk("stall1_pc_d", int'(PC_D), 'hFF8);
    tick();
    chk("stall2_pc_f", int'(PC_F), 'hFFC);
    chk("stall2_pc_d", int'(PC_D), 'hFF8);
    Stall_En = 1'b0;
    tick();
    chk("wrap_pc_f", int'(PC_F), 'h000);
    chk("wrap_pc_d", int'(PC_D), 'hFFC);

    Stall_En = 1'b1;
    redirect_to(12'h123);
    Stall_En = 1'b0;
    chk("redir_stall_pc_f", int'(PC_F), 'h120);
    chk("redir_stall_pred", int'(Pred_Taken_D), 0);
    chk("redir_stall_pc_d", int'(PC_D), 'hFFC);

    btb_update(12'h040, 1'b1, 12'h100);
    redirect_to(12'h040);
    chk("btb_fetch_pc_f", int'(PC_F), 'h040);
    tick();
    chk("btb_pc_d", int'(PC_D), 'h040);
`ifdef FETCH_BTB_EN
    chk("btb_pred_pc_f", int'(PC_F), 'h100);
    chk("btb_pred_taken", int'(Pred_Taken_D), 1);
    chk("btb_pred_target", int'(Pred_Target_D), 'h100);
    btb_update(12'h040, 1'b0, 12'h000);
    btb_update(12'h040, 1'b0, 12'h000);
    redirect_to(12'h040);
    tick();
    chk("sat_nt_pc_f", int'(PC_F), 'h044);
    btb_update(12'h080, 1'b1, 12'h200);
    redirect_to(12'h040);
    tick();
    chk("alias_miss_pc_f", int'(PC_F), 'h044);
    redirect_to(12'h080);
    tick();
    chk("alias_hit_pc_f", int'(PC_F), 'h200);
    chk("alias_hit_pred", int'(Pred_Taken_D), 1);
`else
    chk("nobtb_pc_f", int'(PC_F), 'h044);
    chk("nobtb_pred_taken", int'(Pred_Taken_D), 0);
    chk("nobtb_pred_target", int'(Pred_Target_D), 'h000);
`endif

    // Randomized traffic confined to a small address window so BTB entries get reused.
    for (int c = 0; c < 3000; c++) begin
      RST_N             = ($urandom_range(0, 99) != 0);
      Stall_En          = ($urandom_range(0, 3) == 0);
      Redirect_En_E     = ($urandom_range(0, 9) == 0);
      Redirect_Target_E = 12'($urandom_range(0, 255));
      Update_En_E       = ($urandom_range(0, 2) == 0);
      Update_PC_E       = 12'($urandom_range(0, 255));
      Update_Taken_E    = ($urandom_range(0, 2) != 0);
      Update_Target_E   = 12'($urandom_range(0, 255));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
